// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline hazard control
//                logic (register width, branch opcodes, FSM states and the
//                stall-cause encoding used to steer the stall counters).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Register-specifier width of the base MIPS ISA.
    localparam int         REG_W_DEF   = 5;

    // Opcodes that identify conditional branches resolved in ID.
    localparam logic [5:0] OPC_BEQ_DEF = 6'd4;
    localparam logic [5:0] OPC_BNE_DEF = 6'd5;

    // Data-memory wait controller states.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Reason the pipe is held this cycle; at most one cause is active.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        LOAD_USE = 2'd1,
        BRANCH   = 2'd2,
        MEM_WAIT = 2'd3
    } stall_cause_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // Count qualifying cycles, holding once the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_ms.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_ms
//  Description : ID-stage hazard controller for the 5-stage MIPS pipe.
//                Detects load-use and branch-in-ID dependencies, freezes the
//                pipe while a variable-latency data-memory access is pending,
//                flushes IF/ID on taken branches and keeps saturating stall
//                statistics plus a sticky memory-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_ms
    import pipe_pkg::*;
#(
    parameter int         REG_W        = REG_W_DEF,
    parameter logic [5:0] OPC_BEQ      = OPC_BEQ_DEF,
    parameter logic [5:0] OPC_BNE      = OPC_BNE_DEF,
    parameter bit         BRANCH_IN_ID = 1'b1,
    parameter int         CNT_W        = 16,
    parameter int         TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_id,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic             exmem_mem_read,
    input  logic [REG_W-1:0] write_dst_ex,
    input  logic [REG_W-1:0] write_dst_mem,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic             busy_wait,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mem_wait
);

    // Wait timer only needs to reach TIMEOUT-1; it then holds.
    localparam int                 c_tmr_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    stall_cause_t       w_cause;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_mem_timeout;

    logic [5:0]         w_opcode;
    logic [REG_W-1:0]   w_rs;
    logic [REG_W-1:0]   w_rt;
    logic               w_is_br;
    logic               w_src_hit_ex;
    logic               w_src_hit_mem;
    logic               w_load_use;
    logic               w_br_dep;
    logic               w_unused_inst;

    // ------------------------------------------------------------------------
    // Instruction decode and dependency terms
    // ------------------------------------------------------------------------
    assign w_opcode      = inst_id[31:26];
    assign w_rs          = REG_W'(inst_id[25:21]);
    assign w_rt          = REG_W'(inst_id[20:16]);
    assign w_unused_inst = ^inst_id[15:0];

    assign w_is_br       = (w_opcode == OPC_BEQ) || (w_opcode == OPC_BNE);

    // $zero is never a real producer, so a zero destination cannot match.
    assign w_src_hit_ex  = (write_dst_ex != '0) &&
                           ((write_dst_ex == w_rs) || (write_dst_ex == w_rt));
    assign w_src_hit_mem = (write_dst_mem != '0) &&
                           ((write_dst_mem == w_rs) || (write_dst_mem == w_rt));

    assign w_load_use    = idex_mem_read && w_src_hit_ex;

    // Load-use takes precedence so each stall cycle is charged to one cause.
    assign w_br_dep      = BRANCH_IN_ID && w_is_br && !w_load_use &&
                           ((idex_reg_write && w_src_hit_ex) ||
                            (exmem_mem_read && w_src_hit_mem));

    // ------------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter WAIT on an unfinished access, leave on mem_ready.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (mem_req && !mem_ready) w_state_nxt = WAIT;
            WAIT:    if (mem_ready)             w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Pipeline controls with fixed priority: memory wait, dependency, flush.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        busy_wait   = 1'b0;
        w_cause     = NONE;
        if (rst_n) begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        pipe_freeze = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        w_cause     = MEM_WAIT;
                    end else if (w_load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        w_cause     = LOAD_USE;
                    end else if (w_br_dep) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        w_cause     = BRANCH;
                    end else if (branch_taken && w_is_br) begin
                        ifid_flush  = 1'b1;
                    end
                end
                WAIT: begin
                    // Hazards are not acted on here; they are seen again in RUN.
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    busy_wait   = 1'b1;
                    w_cause     = MEM_WAIT;
                end
                default: begin
                    w_cause     = NONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Wait timer and sticky timeout flag
    // ------------------------------------------------------------------------

    // Held at zero while running, so every WAIT episode starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == RUN) begin
            r_timer <= '0;
        end else if (r_timer != c_tmr_last) begin
            r_timer <= r_timer + c_tmr_w'(1);
        end
    end

    // Set at the end of the TIMEOUT-th WAIT cycle; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_timeout <= 1'b0;
        end else if ((r_state == WAIT) && (r_timer == c_tmr_last)) begin
            r_mem_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_mem_timeout;

    // ------------------------------------------------------------------------
    // Per-cause stall statistics
    // ------------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cause == LOAD_USE),
        .count (cnt_load_use)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_branch (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cause == BRANCH),
        .count (cnt_branch)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mem_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_cause == MEM_WAIT),
        .count (cnt_mem_wait)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_ms.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_ms
//  Description : Self-checking bench for hazard_ctrl_ms. Two instances share
//                stimulus: A uses the defaults (TIMEOUT=64), B has branch
//                checks disabled, 2-bit counters and TIMEOUT=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_ms;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_id;
    logic        idex_mem_read, idex_reg_write, exmem_mem_read;
    logic [4:0]  write_dst_ex, write_dst_mem;
    logic        mem_req, mem_ready, branch_taken;

    logic        a_pc, a_ifid, a_bub, a_fl, a_frz, a_busy, a_tmo;
    logic [15:0] a_clu, a_cbr, a_cmw;
    logic        b_pc, b_ifid, b_bub, b_fl, b_frz, b_busy, b_tmo;
    logic [1:0]  b_clu, b_cbr, b_cmw;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        bit          imr, irw, emr;
        logic [4:0]  dex, dmem;
        bit          req, rdy, tk;
    } in_t;

    typedef struct {
        bit waiting;
        int wcnt;
        bit tmo;
        int clu, cbr, cmw;
    } ms_t;

    typedef struct {
        logic [6:0] ctl;   // {pc, ifid, bubble, flush, freeze, busy, timeout}
        int         clu, cbr, cmw;
    } ex_t;

    typedef struct {
        in_t        x;
        logic [5:0] exp;   // {pc, ifid, bubble, flush, freeze, busy} for A
    } vec_t;

    ms_t sa, sb;

    hazard_ctrl_ms u_dut_a (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .exmem_mem_read(exmem_mem_read), .write_dst_ex(write_dst_ex),
        .write_dst_mem(write_dst_mem), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(a_pc), .ifid_write(a_ifid),
        .idex_bubble(a_bub), .ifid_flush(a_fl), .pipe_freeze(a_frz),
        .busy_wait(a_busy), .mem_timeout(a_tmo), .cnt_load_use(a_clu),
        .cnt_branch(a_cbr), .cnt_mem_wait(a_cmw)
    );

    hazard_ctrl_ms #(.BRANCH_IN_ID(1'b0), .CNT_W(2), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .exmem_mem_read(exmem_mem_read), .write_dst_ex(write_dst_ex),
        .write_dst_mem(write_dst_mem), .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(b_pc), .ifid_write(b_ifid),
        .idex_bubble(b_bub), .ifid_flush(b_fl), .pipe_freeze(b_frz),
        .busy_wait(b_busy), .mem_timeout(b_tmo), .cnt_load_use(b_clu),
        .cnt_branch(b_cbr), .cnt_mem_wait(b_cmw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour for one cycle: expected outputs from the current
    // state, then the state after the clock edge.
    function automatic void model(input bit biid, input int cmax, input int tlim,
                                  input in_t x, input bit rn,
                                  inout ms_t s, output ex_t e);
        logic [5:0] op;
        logic [4:0] rs, rt;
        bit is_br, hex, hmem, lu, bd, pc, ifid, bub, fl, frz;
        op = x.inst[31:26];
        rs = x.inst[25:21];
        rt = x.inst[20:16];
        if (!rn) begin
            s     = '{default: 0};
            e.ctl = 7'b1100000;
            e.clu = 0; e.cbr = 0; e.cmw = 0;
            return;
        end
        is_br = (op == 6'd4) || (op == 6'd5);
        hex   = (x.dex  != '0) && ((x.dex  == rs) || (x.dex  == rt));
        hmem  = (x.dmem != '0) && ((x.dmem == rs) || (x.dmem == rt));
        lu    = x.imr && hex;
        bd    = biid && is_br && ((x.irw && hex) || (x.emr && hmem)) && !lu;
        pc = 1'b1; ifid = 1'b1; bub = 1'b0; fl = 1'b0; frz = 1'b0;
        if (s.waiting || (x.req && !x.rdy)) begin
            pc = 1'b0; ifid = 1'b0; frz = 1'b1;
        end else if (lu || bd) begin
            pc = 1'b0; ifid = 1'b0; bub = 1'b1;
        end else if (x.tk && is_br) begin
            fl = 1'b1;
        end
        e.ctl = {pc, ifid, bub, fl, frz, s.waiting, s.tmo};
        e.clu = s.clu; e.cbr = s.cbr; e.cmw = s.cmw;
        if (frz)     s.cmw = (s.cmw < cmax) ? s.cmw + 1 : cmax;
        else if (lu) s.clu = (s.clu < cmax) ? s.clu + 1 : cmax;
        else if (bd) s.cbr = (s.cbr < cmax) ? s.cbr + 1 : cmax;
        if (s.waiting) begin
            s.wcnt++;
            if (s.wcnt >= tlim) s.tmo = 1'b1;
            if (x.rdy) s.waiting = 1'b0;
        end else if (frz) begin
            s.waiting = 1'b1;
            s.wcnt    = 0;
        end
    endfunction

    function automatic in_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input bit imr, input bit irw, input bit emr,
                               input logic [4:0] dex, input logic [4:0] dmem,
                               input bit req, input bit rdy, input bit tk);
        in_t r;
        r.inst = {op, rs, rt, 16'h0};
        r.imr = imr; r.irw = irw; r.emr = emr;
        r.dex = dex; r.dmem = dmem;
        r.req = req; r.rdy = rdy; r.tk = tk;
        return r;
    endfunction

    // Apply one cycle of stimulus and compare both instances with the model.
    task automatic cycle(input in_t x, input bit rn);
        ex_t ea, eb;
        @(posedge clk);
        #1;
        inst_id        = x.inst;
        idex_mem_read  = x.imr;
        idex_reg_write = x.irw;
        exmem_mem_read = x.emr;
        write_dst_ex   = x.dex;
        write_dst_mem  = x.dmem;
        mem_req        = x.req;
        mem_ready      = x.rdy;
        branch_taken   = x.tk;
        rst_n          = rn;
        @(negedge clk);
        model(1'b1, 65535, 64, x, rn, sa, ea);
        model(1'b0, 3, 4, x, rn, sb, eb);
        chk("A.ctl", 32'({a_pc, a_ifid, a_bub, a_fl, a_frz, a_busy, a_tmo}), 32'(ea.ctl));
        chk("A.cnt_load_use", 32'(a_clu), ea.clu);
        chk("A.cnt_branch",   32'(a_cbr), ea.cbr);
        chk("A.cnt_mem_wait", 32'(a_cmw), ea.cmw);
        chk("B.ctl", 32'({b_pc, b_ifid, b_bub, b_fl, b_frz, b_busy, b_tmo}), 32'(eb.ctl));
        chk("B.cnt_load_use", 32'(b_clu), eb.clu);
        chk("B.cnt_branch",   32'(b_cbr), eb.cbr);
        chk("B.cnt_mem_wait", 32'(b_cmw), eb.cmw);
    endtask

    vec_t tv[16];
    in_t  idle, lu_in, wt, rx;

    initial begin
        idle  = mk(6'd0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0);
        lu_in = mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 0, 0, 0);
        wt    = mk(6'd0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 5'd0, 1, 0, 0);

        //            op     rs     rt   imr irw emr  dex    dmem  req rdy tk   pc ifid bub fl frz busy
        tv[0]  = '{mk(6'd0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0), 6'b110000};
        tv[1]  = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 0, 0, 0), 6'b001000};
        tv[2]  = '{mk(6'd0, 5'd0, 5'd3, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0), 6'b110000};
        tv[3]  = '{mk(6'd4, 5'd9, 5'd1, 0, 1, 0, 5'd9, 5'd0, 0, 0, 0), 6'b001000};
        tv[4]  = '{mk(6'd4, 5'd9, 5'd1, 0, 0, 1, 5'd0, 5'd9, 0, 0, 0), 6'b001000};
        tv[5]  = '{mk(6'd4, 5'd2, 5'd3, 0, 0, 0, 5'd0, 5'd0, 0, 0, 1), 6'b110100};
        tv[6]  = '{mk(6'd0, 5'd2, 5'd3, 0, 0, 0, 5'd0, 5'd0, 0, 0, 1), 6'b110000};
        tv[7]  = '{mk(6'd0, 5'd1, 5'd7, 1, 0, 0, 5'd7, 5'd0, 0, 0, 0), 6'b001000};
        tv[8]  = '{mk(6'd5, 5'd3, 5'd4, 0, 0, 0, 5'd0, 5'd0, 1, 1, 1), 6'b110100};
        tv[9]  = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 1, 0, 0), 6'b000010};
        tv[10] = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 1, 0, 0), 6'b000011};
        tv[11] = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 1, 0, 0), 6'b000011};
        tv[12] = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 1, 1, 0), 6'b000011};
        tv[13] = '{mk(6'd0, 5'd8, 5'd2, 1, 0, 0, 5'd8, 5'd0, 0, 0, 0), 6'b001000};
        tv[14] = '{mk(6'd4, 5'd9, 5'd0, 1, 1, 0, 5'd9, 5'd0, 0, 0, 0), 6'b001000};
        tv[15] = '{mk(6'd0, 5'd1, 5'd2, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0), 6'b110000};

        sa = '{default: 0};
        sb = '{default: 0};
        rst_n = 1'b0;
        inst_id = lu_in.inst;
        idex_mem_read = 1'b1; idex_reg_write = 1'b0; exmem_mem_read = 1'b0;
        write_dst_ex = 5'd8; write_dst_mem = 5'd0;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;

        // Reset: outputs forced to the run defaults even with a hazard present.
        cycle(lu_in, 1'b0);
        cycle(lu_in, 1'b0);
        chk("rst.pc_write", 32'(a_pc), 1);
        chk("rst.bubble",   32'(a_bub), 0);
        cycle(idle, 1'b1);
        chk("rst.idle_ctl", 32'({a_pc, a_ifid, a_bub, a_fl, a_frz, a_busy}), 32'(6'b110000));
        chk("rst.cnt_sum",  32'(a_clu) + 32'(a_cbr) + 32'(a_cmw), 0);

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            cycle(tv[i].x, 1'b1);
            chk($sformatf("tbl%0d.ctl", i),
                32'({a_pc, a_ifid, a_bub, a_fl, a_frz, a_busy}), 32'(tv[i].exp));
        end
        chk("tbl.A_cnt_load_use", 32'(a_clu), 4);
        chk("tbl.A_cnt_branch",   32'(a_cbr), 2);
        chk("tbl.A_cnt_mem_wait", 32'(a_cmw), 4);
        chk("tbl.B_cnt_load_use", 32'(b_clu), 3);
        chk("tbl.B_cnt_branch",   32'(b_cbr), 0);
        chk("tbl.B_cnt_mem_wait", 32'(b_cmw), 3);
        chk("tbl.B_timeout",      32'(b_tmo), 0);

        // Timeout: B flags after four WAIT cycles and keeps waiting.
        cycle(wt, 1'b1);
        for (int w = 1; w <= 7; w++) begin
            cycle(wt, 1'b1);
            chk("to.B_busy", 32'(b_busy), 1);
            if (w >= 5) chk("to.B_timeout_set", 32'(b_tmo), 1);
            else        chk("to.B_timeout_clr", 32'(b_tmo), 0);
        end
        chk("to.A_timeout", 32'(a_tmo), 0);

        // Reset asserted mid-WAIT.
        cycle(wt, 1'b0);
        chk("midrst.B_busy",    32'(b_busy), 0);
        chk("midrst.B_timeout", 32'(b_tmo), 0);
        chk("midrst.B_cnt_mw",  32'(b_cmw), 0);
        chk("midrst.A_freeze",  32'(a_frz), 0);
        cycle(idle, 1'b1);
        chk("midrst.A_run", 32'({a_pc, a_ifid, a_frz, a_busy}), 32'(4'b1100));

        // Saturation: five load-use stalls.
        repeat (5) cycle(lu_in, 1'b1);
        cycle(idle, 1'b1);
        chk("sat.A_cnt_load_use", 32'(a_clu), 5);
        chk("sat.B_cnt_load_use", 32'(b_clu), 3);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0:       op = 6'd0;
                1:       op = 6'd4;
                2:       op = 6'd5;
                default: op = 6'($urandom);
            endcase
            rx.inst = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            rx.imr  = ($urandom_range(0, 2) == 0);
            rx.irw  = ($urandom_range(0, 1) == 0);
            rx.emr  = ($urandom_range(0, 2) == 0);
            rx.dex  = 5'($urandom_range(0, 3));
            rx.dmem = 5'($urandom_range(0, 3));
            rx.req  = ($urandom_range(0, 3) == 0);
            rx.rdy  = ($urandom_range(0, 2) == 0);
            rx.tk   = ($urandom_range(0, 1) == 0);
            cycle(rx, ($urandom_range(0, 299) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
